// File: rtl/falco_dmem_if.sv
// ----------------------------------------------------------------------------
// falco_dmem_if
//   Bundle of the Falco core data-port signals between the core (master) and
//   the memory-side responder (slave).
//
//   Handshake rule for every valid/ready pair in this bundle: a transfer
//   happens on a rising clock edge where valid and ready are both 1. The
//   sender holds valid and payload stable until that edge. Ready may be
//   raised or lowered at any time and never depends on valid.
//   The hit and store responses are one-cycle pulses with no ready.
//
//   Groups:
//     load_req_*   core -> responder load request (valid/ready, addr, tag)
//     store_req_*  core -> responder store request (valid/ready, addr, data, be, tag)
//     load_hit_*   responder -> core hit pulse (valid, tag, hit)
//     load_data_*  responder -> core load data (valid/ready, tag, data, err)
//     store_resp_* responder -> core store completion pulse (valid, tag, err)
//     dbg_state    responder FSM state (0 = INIT, 1 = RUN)
// ----------------------------------------------------------------------------
interface falco_dmem_if #(
    parameter int XLEN_WIDTH = 64,
    parameter int TAG_WIDTH  = 4
);
    logic                      load_req_valid;
    logic                      load_req_ready;
    logic [XLEN_WIDTH-1:0]     load_req_addr;
    logic [TAG_WIDTH-1:0]      load_req_tag;

    logic                      store_req_valid;
    logic                      store_req_ready;
    logic [XLEN_WIDTH-1:0]     store_req_addr;
    logic [XLEN_WIDTH-1:0]     store_req_data;
    logic [XLEN_WIDTH/8-1:0]   store_req_be;
    logic [TAG_WIDTH-1:0]      store_req_tag;

    logic                      load_hit_valid;
    logic [TAG_WIDTH-1:0]      load_hit_tag;
    logic                      load_hit;

    logic                      load_data_valid;
    logic                      load_data_ready;
    logic [TAG_WIDTH-1:0]      load_data_tag;
    logic [XLEN_WIDTH-1:0]     load_data;
    logic                      load_data_err;

    logic                      store_resp_valid;
    logic [TAG_WIDTH-1:0]      store_resp_tag;
    logic                      store_resp_err;

    logic                      dbg_state;

    modport master (
        output load_req_valid, load_req_addr, load_req_tag,
        input  load_req_ready,
        output store_req_valid, store_req_addr, store_req_data, store_req_be, store_req_tag,
        input  store_req_ready,
        input  load_hit_valid, load_hit_tag, load_hit,
        input  load_data_valid, load_data_tag, load_data, load_data_err,
        output load_data_ready,
        input  store_resp_valid, store_resp_tag, store_resp_err,
        input  dbg_state
    );

    modport slave (
        input  load_req_valid, load_req_addr, load_req_tag,
        output load_req_ready,
        input  store_req_valid, store_req_addr, store_req_data, store_req_be, store_req_tag,
        output store_req_ready,
        output load_hit_valid, load_hit_tag, load_hit,
        output load_data_valid, load_data_tag, load_data, load_data_err,
        input  load_data_ready,
        output store_resp_valid, store_resp_tag, store_resp_err,
        output dbg_state
    );
endinterface

// File: rtl/falco_dmem_responder.sv
// ----------------------------------------------------------------------------
// falco_dmem_responder
//   Memory-side endpoint for the Falco core data port. Holds a word-organised
//   backing RAM (cleared after reset), answers loads with a hit pulse and a
//   fixed-minimum-latency, strictly in-order data return, and answers stores
//   with a completion pulse.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset; drops any loads in flight
//   bus    falco_dmem_if.slave: load/store requests, hit pulse, load data
//          return, store completion pulse, dbg_state (0 = INIT, 1 = RUN)
// ----------------------------------------------------------------------------
module falco_dmem_responder #(
    parameter int XLEN_WIDTH = 64,
    parameter int TAG_WIDTH  = 4,
    parameter int MEM_DEPTH  = 256,
    parameter int LOAD_LAT   = 3,
    parameter int QDEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    falco_dmem_if.slave bus
);
    localparam int LANES   = XLEN_WIDTH / 8;
    localparam int LANE_W  = $clog2(LANES);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int CNT_W   = $clog2(QDEPTH + 1);
    localparam int AGE_W   = $clog2(LOAD_LAT);
    localparam int AGE_MAX = LOAD_LAT - 1;

    // ------------------------------------------------------------------
    // INIT / RUN state machine
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] init_cnt;
    logic [IDX_W-1:0] init_cnt_next;
    logic             init_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        init_we       = 1'b0;
        case (state)
            ST_INIT: begin
                init_we       = 1'b1;
                init_cnt_next = init_cnt + IDX_W'(1);
                if (init_cnt == IDX_W'(MEM_DEPTH - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    logic run;
    assign run           = (state == ST_RUN);
    assign bus.dbg_state = run;

    // ------------------------------------------------------------------
    // Address decode: a request is in range only when every address bit
    // above the word-index field is zero. Lane bits are ignored.
    // ------------------------------------------------------------------
    function automatic logic addr_in_range(input logic [XLEN_WIDTH-1:0] a);
        return (a >> (LANE_W + IDX_W)) == '0;
    endfunction

    logic             ld_in_range;
    logic             st_in_range;
    logic [IDX_W-1:0] ld_idx;
    logic [IDX_W-1:0] st_idx;

    assign ld_in_range = addr_in_range(bus.load_req_addr);
    assign st_in_range = addr_in_range(bus.store_req_addr);
    assign ld_idx      = bus.load_req_addr[LANE_W +: IDX_W];
    assign st_idx      = bus.store_req_addr[LANE_W +: IDX_W];

    // ------------------------------------------------------------------
    // Load queue bookkeeping (count includes the entry currently presented)
    // ------------------------------------------------------------------
    logic [TAG_WIDTH-1:0]  q_tag  [QDEPTH];
    logic [XLEN_WIDTH-1:0] q_data [QDEPTH];
    logic                  q_err  [QDEPTH];
    logic [AGE_W-1:0]      q_age  [QDEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic load_ready;
    logic load_acc;
    logic store_acc;

    // Ready comes from the registered count, so a dequeue in the same
    // cycle cannot reopen a full queue until the following cycle.
    assign load_ready          = run && (count < CNT_W'(QDEPTH));
    assign bus.load_req_ready  = load_ready;
    assign bus.store_req_ready = run;
    assign load_acc            = bus.load_req_valid && load_ready;
    assign store_acc           = bus.store_req_valid && run;

    // ------------------------------------------------------------------
    // Backing RAM. The load path reads combinationally at accept, so a
    // store landing on the same edge is not yet visible to that load.
    // ------------------------------------------------------------------
    logic [XLEN_WIDTH-1:0] mem [MEM_DEPTH];
    logic [XLEN_WIDTH-1:0] ld_word;

    assign ld_word = ld_in_range ? mem[ld_idx] : '0;

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_cnt] <= '0;
        end else if (store_acc && st_in_range) begin
            for (int b = 0; b < LANES; b++) begin
                if (bus.store_req_be[b]) begin
                    mem[st_idx][8*b +: 8] <= bus.store_req_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Data return. The output register holds the oldest entry while it
    // waits for the core; the next candidate is the entry behind it.
    // An entry is loaded into the output register on the edge where its
    // age steps to LOAD_LAT-1, which puts data_valid at accept+LOAD_LAT.
    // ------------------------------------------------------------------
    logic                  data_valid_r;
    logic [TAG_WIDTH-1:0]  data_tag_r;
    logic [XLEN_WIDTH-1:0] data_r;
    logic                  data_err_r;

    logic             deq;
    logic [PTR_W-1:0] cand_ptr;
    logic             cand_avail;
    logic             cand_ripe;
    logic             present;

    assign deq        = data_valid_r && bus.load_data_ready;
    assign cand_ptr   = data_valid_r ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    assign cand_avail = data_valid_r ? (count >= CNT_W'(2)) : (count >= CNT_W'(1));
    assign cand_ripe  = (q_age[cand_ptr] >= AGE_W'(LOAD_LAT - 2));
    assign present    = (!data_valid_r || bus.load_data_ready) && cand_avail && cand_ripe;

    // Response pulse registers
    logic                 hit_valid_r;
    logic [TAG_WIDTH-1:0] hit_tag_r;
    logic                 hit_r;
    logic                 st_valid_r;
    logic [TAG_WIDTH-1:0] st_tag_r;
    logic                 st_err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_valid_r <= 1'b0;
            data_tag_r   <= '0;
            data_r       <= '0;
            data_err_r   <= 1'b0;
            hit_valid_r  <= 1'b0;
            hit_tag_r    <= '0;
            hit_r        <= 1'b0;
            st_valid_r   <= 1'b0;
            st_tag_r     <= '0;
            st_err_r     <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_tag[i]  <= '0;
                q_data[i] <= '0;
                q_err[i]  <= 1'b0;
                q_age[i]  <= '0;
            end
        end else begin
            // Ages saturate; unused slots age harmlessly and are reset on enqueue.
            for (int i = 0; i < QDEPTH; i++) begin
                if (q_age[i] != AGE_W'(AGE_MAX)) begin
                    q_age[i] <= q_age[i] + AGE_W'(1);
                end
            end

            if (load_acc) begin
                q_tag[wr_ptr]  <= bus.load_req_tag;
                q_data[wr_ptr] <= ld_word;
                q_err[wr_ptr]  <= !ld_in_range;
                q_age[wr_ptr]  <= '0;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end

            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            count <= count + CNT_W'(load_acc) - CNT_W'(deq);

            if (present) begin
                data_valid_r <= 1'b1;
                data_tag_r   <= q_tag[cand_ptr];
                data_r       <= q_data[cand_ptr];
                data_err_r   <= q_err[cand_ptr];
            end else if (deq) begin
                data_valid_r <= 1'b0;
            end

            hit_valid_r <= load_acc;
            if (load_acc) begin
                hit_tag_r <= bus.load_req_tag;
                hit_r     <= ld_in_range;
            end

            st_valid_r <= store_acc;
            if (store_acc) begin
                st_tag_r <= bus.store_req_tag;
                st_err_r <= !st_in_range;
            end
        end
    end

    assign bus.load_hit_valid   = hit_valid_r;
    assign bus.load_hit_tag     = hit_tag_r;
    assign bus.load_hit         = hit_r;
    assign bus.load_data_valid  = data_valid_r;
    assign bus.load_data_tag    = data_tag_r;
    assign bus.load_data        = data_r;
    assign bus.load_data_err    = data_err_r;
    assign bus.store_resp_valid = st_valid_r;
    assign bus.store_resp_tag   = st_tag_r;
    assign bus.store_resp_err   = st_err_r;

endmodule

// File: tb/tb_falco_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_falco_dmem_responder
//   Bench for falco_dmem_responder: reset/INIT timing, a table of single
//   load/store vectors, hand-timed sequences for latency, back-pressure,
//   collisions and mid-flight reset, then randomized traffic against a
//   word-array memory model with an expected-response queue.
// ----------------------------------------------------------------------------
module tb_falco_dmem_responder;
    localparam int XLEN  = 64;
    localparam int TAGW  = 4;
    localparam int DEPTH = 256;
    localparam int LAT   = 3;
    localparam int QD    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    falco_dmem_if #(.XLEN_WIDTH(XLEN), .TAG_WIDTH(TAGW)) bus ();

    falco_dmem_responder #(
        .XLEN_WIDTH(XLEN), .TAG_WIDTH(TAGW), .MEM_DEPTH(DEPTH),
        .LOAD_LAT(LAT), .QDEPTH(QD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] model_mem [DEPTH];
    logic [68:0] exp_q[$];   // {tag, err, data}
    int          acc_q[$];   // accept cycle per expected response

    function automatic bit m_in_range(input logic [63:0] a);
        return (a >> 11) == 64'd0;
    endfunction

    function automatic int m_idx(input logic [63:0] a);
        return int'((a >> 3) % 64'(DEPTH));
    endfunction

    // ---------------- scoreboard monitor ----------------
    bit          hit_due = 0;
    logic [3:0]  hit_due_tag;
    bit          hit_due_hit;
    bit          st_due = 0;
    logic [3:0]  st_due_tag;
    bit          st_due_err;
    bit          stalled = 0;
    logic [68:0] stall_val;
    int          data_seen = 0;

    always @(negedge clk) begin
        logic [68:0] cur;
        logic [68:0] e;
        int          a;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            hit_due = 0;
            st_due  = 0;
            stalled = 0;
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'd0;
        end else begin
            if (hit_due || bus.load_hit_valid) begin
                check("mon_hit_valid", bus.load_hit_valid, hit_due);
                if (hit_due) begin
                    check("mon_hit_tag", bus.load_hit_tag, hit_due_tag);
                    check("mon_hit", bus.load_hit, hit_due_hit);
                end
            end
            if (st_due || bus.store_resp_valid) begin
                check("mon_store_resp_valid", bus.store_resp_valid, st_due);
                if (st_due) begin
                    check("mon_store_resp_tag", bus.store_resp_tag, st_due_tag);
                    check("mon_store_resp_err", bus.store_resp_err, st_due_err);
                end
            end

            cur = {bus.load_data_tag, bus.load_data_err, bus.load_data};
            if (stalled) begin
                check("mon_data_hold_valid", bus.load_data_valid, 1);
                check("mon_data_hold_value", cur, stall_val);
            end
            stalled = 0;
            if (bus.load_data_valid) begin
                data_seen++;
                if (bus.load_data_ready) begin
                    check("mon_data_expected_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("mon_data_resp", cur, e);
                        check("mon_data_min_latency", (cyc - a) >= (LAT - 1), 1);
                    end
                end else begin
                    stalled   = 1;
                    stall_val = cur;
                end
            end

            // Accepts that happen on the coming edge
            hit_due = bus.load_req_valid && bus.load_req_ready;
            if (hit_due) begin
                hit_due_tag = bus.load_req_tag;
                hit_due_hit = m_in_range(bus.load_req_addr);
                exp_q.push_back({bus.load_req_tag, !hit_due_hit,
                                 hit_due_hit ? model_mem[m_idx(bus.load_req_addr)] : 64'd0});
                acc_q.push_back(cyc + 1);
            end
            st_due = bus.store_req_valid && bus.store_req_ready;
            if (st_due) begin
                st_due_tag = bus.store_req_tag;
                st_due_err = !m_in_range(bus.store_req_addr);
                if (!st_due_err) begin
                    for (int b = 0; b < 8; b++) begin
                        if (bus.store_req_be[b])
                            model_mem[m_idx(bus.store_req_addr)][8*b +: 8] = bus.store_req_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic idle_inputs();
        bus.load_req_valid  = 0;
        bus.load_req_addr   = '0;
        bus.load_req_tag    = '0;
        bus.store_req_valid = 0;
        bus.store_req_addr  = '0;
        bus.store_req_data  = '0;
        bus.store_req_be    = '0;
        bus.store_req_tag   = '0;
        bus.load_data_ready = 1;
    endtask

    task automatic wait_data(output logic [63:0] d, output logic [3:0] t, output logic e);
        bit got;
        got = 0;
        d = '0;
        t = '0;
        e = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.load_data_valid && bus.load_data_ready) begin
                d = bus.load_data;
                t = bus.load_data_tag;
                e = bus.load_data_err;
                got = 1;
                break;
            end
        end
        check("data_wait_in_budget", got, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] addr, input logic [3:0] tag,
                           output logic [63:0] d, output logic [3:0] t,
                           output logic e, output logic h);
        bit ok;
        ok = 0;
        bus.load_req_valid = 1;
        bus.load_req_addr  = addr;
        bus.load_req_tag   = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.load_req_ready) begin ok = 1; break; end
        end
        check("load_accept_in_budget", ok, 1);
        @(posedge clk);
        #1;
        bus.load_req_valid = 0;
        @(negedge clk);
        check("load_hit_pulse", bus.load_hit_valid, 1);
        h = bus.load_hit;
        wait_data(d, t, e);
    endtask

    task automatic do_store(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] be, input logic [3:0] tag, output logic e);
        bit ok;
        ok = 0;
        bus.store_req_valid = 1;
        bus.store_req_addr  = addr;
        bus.store_req_data  = data;
        bus.store_req_be    = be;
        bus.store_req_tag   = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.store_req_ready) begin ok = 1; break; end
        end
        check("store_accept_in_budget", ok, 1);
        @(posedge clk);
        #1;
        bus.store_req_valid = 0;
        @(negedge clk);
        check("store_resp_at_t1", bus.store_resp_valid, 1);
        check("store_resp_tag", bus.store_resp_tag, tag);
        e = bus.store_resp_err;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) a = a | (64'd1 << $urandom_range(11, 40));
        return a;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_store;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [3:0]  tag;
        logic [63:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs[13];

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] d;
        logic [3:0]  t;
        logic        e;
        logic        h;
        int          n;
        int          got;
        int          deq_done;
        bit          acc4;
        bit          acc4_pending;
        bit          ld_took;
        bit          st_took;
        int          seen0;

        vecs[0]  = '{0, 64'h0,       64'h0,                 8'h00, 4'd1,  64'h0,                 0};
        vecs[1]  = '{1, 64'h40,      64'h1122334455667788,  8'hFF, 4'd3,  64'h0,                 0};
        vecs[2]  = '{0, 64'h40,      64'h0,                 8'h00, 4'd5,  64'h1122334455667788,  0};
        vecs[3]  = '{1, 64'h48,      64'hFFFFFFFFFFFFFFFF,  8'hFF, 4'd2,  64'h0,                 0};
        vecs[4]  = '{1, 64'h48,      64'hAAAAAAAABBBBBBBB,  8'h0F, 4'd6,  64'h0,                 0};
        vecs[5]  = '{0, 64'h48,      64'h0,                 8'h00, 4'd7,  64'hFFFFFFFFBBBBBBBB,  0};
        vecs[6]  = '{0, 64'h10000,   64'h0,                 8'h00, 4'd8,  64'h0,                 1};
        vecs[7]  = '{1, 64'h10000,   64'hDEADBEEFCAFEF00D,  8'hFF, 4'd9,  64'h0,                 1};
        vecs[8]  = '{0, 64'h0,       64'h0,                 8'h00, 4'd10, 64'h0,                 0};
        vecs[9]  = '{0, 64'h44,      64'h0,                 8'h00, 4'd11, 64'h1122334455667788,  0};
        vecs[10] = '{1, 64'h7F8,     64'h0123456789ABCDEF,  8'hF0, 4'd12, 64'h0,                 0};
        vecs[11] = '{0, 64'h7F8,     64'h0,                 8'h00, 4'd13, 64'h0123456700000000,  0};
        vecs[12] = '{0, 64'h800,     64'h0,                 8'h00, 4'd14, 64'h0,                 1};

        // Reset state
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_load_ready", bus.load_req_ready, 0);
        check("rst_store_ready", bus.store_req_ready, 0);
        check("rst_hit_valid", bus.load_hit_valid, 0);
        check("rst_data_valid", bus.load_data_valid, 0);
        check("rst_data", bus.load_data, 64'd0);
        check("rst_store_resp_valid", bus.store_resp_valid, 0);
        check("rst_dbg_state", bus.dbg_state, 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // INIT duration
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.load_req_ready) break;
            if (bus.store_req_ready) check("init_store_ready_low", bus.store_req_ready, 0);
            n++;
        end
        check("init_cycles", n, DEPTH);
        check("run_store_ready", bus.store_req_ready, 1);
        check("run_dbg_state", bus.dbg_state, 1);
        @(posedge clk);
        #1;

        // Table vectors
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_store) begin
                do_store(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].tag, e);
                check($sformatf("vec%0d_store_err", i), e, vecs[i].exp_err);
            end else begin
                do_load(vecs[i].addr, vecs[i].tag, d, t, e, h);
                check($sformatf("vec%0d_load_data", i), d, vecs[i].exp_data);
                check($sformatf("vec%0d_load_err", i), e, vecs[i].exp_err);
                check($sformatf("vec%0d_load_tag", i), t, vecs[i].tag);
                check($sformatf("vec%0d_load_hit", i), h, !vecs[i].exp_err);
            end
        end

        // Exact load latency
        bus.load_req_valid = 1;
        bus.load_req_addr  = 64'h40;
        bus.load_req_tag   = 4'd5;
        @(negedge clk);
        check("lat_ready", bus.load_req_ready, 1);
        @(posedge clk);
        #1;
        bus.load_req_valid = 0;
        @(negedge clk);
        check("lat_t1_hit_valid", bus.load_hit_valid, 1);
        check("lat_t1_hit_tag", bus.load_hit_tag, 4'd5);
        check("lat_t1_hit", bus.load_hit, 1);
        check("lat_t1_data_valid", bus.load_data_valid, 0);
        @(negedge clk);
        check("lat_t2_hit_valid", bus.load_hit_valid, 0);
        check("lat_t2_data_valid", bus.load_data_valid, 0);
        @(negedge clk);
        check("lat_t3_data_valid", bus.load_data_valid, 1);
        check("lat_t3_data", bus.load_data, 64'h1122334455667788);
        check("lat_t3_tag", bus.load_data_tag, 4'd5);
        @(posedge clk);
        #1;

        // Back-pressure and full queue
        for (int i = 0; i < 5; i++) begin
            do_store(64'h100 + 64'(8 * i), 64'h1000 + 64'(i), 8'hFF, 4'(i), e);
        end
        bus.load_data_ready = 0;
        for (int i = 0; i < 4; i++) begin
            bus.load_req_valid = 1;
            bus.load_req_addr  = 64'h100 + 64'(8 * i);
            bus.load_req_tag   = 4'(i);
            @(negedge clk);
            check("bp_ready_open", bus.load_req_ready, 1);
            @(posedge clk);
            #1;
        end
        bus.load_req_addr = 64'h120;
        bus.load_req_tag  = 4'd4;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_ready_full", bus.load_req_ready, 0);
            check("bp_head_valid", bus.load_data_valid, 1);
            check("bp_head_tag", bus.load_data_tag, 4'd0);
            check("bp_head_data", bus.load_data, 64'h1000);
        end
        @(posedge clk);
        #1;
        bus.load_data_ready = 1;
        got = 0;
        deq_done = 0;
        acc4 = 0;
        acc4_pending = 0;
        for (int k = 0; k < 60 && got < 5; k++) begin
            @(negedge clk);
            if (!acc4 && !acc4_pending && bus.load_req_ready) begin
                check("bp_reopen_after_deq", deq_done >= 1, 1);
                acc4_pending = 1;
            end
            if (bus.load_data_valid && bus.load_data_ready) begin
                if (deq_done == 0) check("bp_no_same_cycle_reopen", bus.load_req_ready, 0);
                check("bp_order_tag", bus.load_data_tag, 4'(got));
                check("bp_order_data", bus.load_data, 64'h1000 + 64'(got));
                got++;
                deq_done++;
            end
            @(posedge clk);
            #1;
            if (acc4_pending && !acc4) begin
                bus.load_req_valid = 0;
                acc4 = 1;
            end
        end
        check("bp_all_returned", got, 5);
        check("bp_tag4_accepted", acc4, 1);
        bus.load_req_valid = 0;

        // Same-cycle load and store to one word
        do_store(64'h80, 64'h1, 8'hFF, 4'd1, e);
        bus.load_req_valid  = 1;
        bus.load_req_addr   = 64'h80;
        bus.load_req_tag    = 4'd9;
        bus.store_req_valid = 1;
        bus.store_req_addr  = 64'h80;
        bus.store_req_data  = 64'h22;
        bus.store_req_be    = 8'hFF;
        bus.store_req_tag   = 4'd10;
        @(negedge clk);
        check("coll_load_ready", bus.load_req_ready, 1);
        check("coll_store_ready", bus.store_req_ready, 1);
        @(posedge clk);
        #1;
        bus.load_req_valid  = 0;
        bus.store_req_valid = 0;
        wait_data(d, t, e);
        check("coll_old_data", d, 64'h1);
        check("coll_tag", t, 4'd9);
        do_load(64'h80, 4'd11, d, t, e, h);
        check("coll_new_data", d, 64'h22);

        // Async reset with two loads in flight
        bus.load_req_valid = 1;
        bus.load_req_addr  = 64'h0;
        bus.load_req_tag   = 4'd1;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.load_req_tag = 4'd2;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.load_req_valid = 0;
        #2;
        rst_n = 0;
        @(negedge clk);
        check("mrst_data_valid", bus.load_data_valid, 0);
        check("mrst_hit_valid", bus.load_hit_valid, 0);
        check("mrst_load_ready", bus.load_req_ready, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        seen0 = data_seen;
        repeat (DEPTH + 20) @(negedge clk);
        check("mrst_no_data_after", data_seen - seen0, 0);
        check("mrst_back_to_run", bus.load_req_ready, 1);
        @(posedge clk);
        #1;

        // Randomized traffic
        ld_took = 0;
        st_took = 0;
        for (int c = 0; c < 500; c++) begin
            if (!bus.load_req_valid || ld_took) begin
                bus.load_req_valid = ($urandom_range(0, 2) != 0);
                bus.load_req_addr  = rand_addr();
                bus.load_req_tag   = 4'($urandom_range(0, 15));
            end
            if (!bus.store_req_valid || st_took) begin
                bus.store_req_valid = ($urandom_range(0, 2) == 0);
                bus.store_req_addr  = rand_addr();
                bus.store_req_data  = {$urandom(), $urandom()};
                bus.store_req_be    = 8'($urandom_range(0, 255));
                bus.store_req_tag   = 4'($urandom_range(0, 15));
            end
            bus.load_data_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ld_took = bus.load_req_valid && bus.load_req_ready;
            st_took = bus.store_req_valid && bus.store_req_ready;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.load_data_valid) break;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_data_idle", bus.load_data_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
